// File: rtl/regfile_pkg.sv
// Shared types for the scoreboarded register-read stage.
// Operand use encodings, use-field width and use decoding helpers.
package regfile_pkg;

  localparam int USE_W = 2;

  typedef enum logic [USE_W-1:0] {
    REG_IMM        = 2'd0,
    REG_READ       = 2'd1,
    REG_WRITE      = 2'd2,
    REG_READ_WRITE = 2'd3
  } reg_use_e;

  function automatic logic use_rd(reg_use_e u);
    return (u == REG_READ) || (u == REG_READ_WRITE);
  endfunction

  function automatic logic use_wr(reg_use_e u);
    return (u == REG_WRITE) || (u == REG_READ_WRITE);
  endfunction

endpackage

// File: rtl/fx_scoreboard_regfile_if.sv
// Issue, operand, writeback and debug bus of the register-read stage.
// slave: the stage itself; master: decode/exec/writeback side.
interface fx_scoreboard_regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_RD     = 3,
  parameter int NUM_WB     = 2,
  parameter int TAG_W      = 16
) ();

  logic                         issue_valid_i;
  logic                         issue_ready_o;
  logic [NUM_RD-1:0]            rd_en_i;
  logic [NUM_RD*REG_ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD*USE_W-1:0]      rd_use_i;
  logic [NUM_RD-1:0]            rd_zero_i;
  logic [TAG_W-1:0]             tag_i;

  logic                         op_valid_o;
  logic                         op_ready_i;
  logic [NUM_RD*DATA_W-1:0]     operand_o;
  logic [NUM_RD-1:0]            dest_valid_o;
  logic [NUM_RD*REG_ADDR_W-1:0] dest_addr_o;
  logic [TAG_W-1:0]             tag_o;

  logic [NUM_WB-1:0]            wb_en_i;
  logic [NUM_WB*REG_ADDR_W-1:0] wb_addr_i;
  logic [NUM_WB*DATA_W-1:0]     wb_data_i;

  logic [REG_ADDR_W-1:0]        dbg_addr_i;
  logic [DATA_W-1:0]            dbg_data_o;

  modport slave (
    input  issue_valid_i, rd_en_i, rd_addr_i,
    input  rd_use_i, rd_zero_i, tag_i,
    output issue_ready_o,
    output op_valid_o, operand_o, dest_valid_o,
    output dest_addr_o, tag_o,
    input  op_ready_i,
    input  wb_en_i, wb_addr_i, wb_data_i,
    input  dbg_addr_i,
    output dbg_data_o
  );

  modport master (
    output issue_valid_i, rd_en_i, rd_addr_i,
    output rd_use_i, rd_zero_i, tag_i,
    input  issue_ready_o,
    input  op_valid_o, operand_o, dest_valid_o,
    input  dest_addr_o, tag_o,
    output op_ready_i,
    output wb_en_i, wb_addr_i, wb_data_i,
    output dbg_addr_i,
    input  dbg_data_o
  );

endinterface

// File: rtl/fx_scoreboard.sv
// Pending-write scoreboard and per-port RAW/WAW hazard detection.
// Ports: clk, rst, accept, rd_* per operand port, wb_en/wb_addr, hazard.
// REGFILE_WB_BYPASS_EN: a same-cycle writeback satisfies the hazard.
module fx_scoreboard
  import regfile_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 2**REG_ADDR_W,
  parameter int NUM_RD     = 3,
  parameter int NUM_WB     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         accept,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*REG_ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD*USE_W-1:0]      rd_use,
  input  logic [NUM_RD-1:0]            rd_zero,
  input  logic [NUM_WB-1:0]            wb_en,
  input  logic [NUM_WB*REG_ADDR_W-1:0] wb_addr,
  output logic                         hazard
);

  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pend_nxt;
  logic [REG_ADDR_W-1:0] a;
  reg_use_e              u;
  logic                  byp;
  logic                  rh;
  logic                  wh;

  always_comb begin
    hazard = 1'b0;
    a = '0;
    u = REG_IMM;
    byp = 1'b0;
    rh = 1'b0;
    wh = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      a = rd_addr[(NUM_RD-1-p)*REG_ADDR_W +: REG_ADDR_W];
      u = reg_use_e'(rd_use[(NUM_RD-1-p)*USE_W +: USE_W]);
      byp = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
      for (int w = 0; w < NUM_WB; w++)
        if (wb_en[w] &&
            wb_addr[(NUM_WB-1-w)*REG_ADDR_W +: REG_ADDR_W] == a)
          byp = 1'b1;
`endif
      // a hard-wired zero read never depends on r0
      rh = use_rd(u) && pending[a] &&
           !(rd_zero[p] && a == '0);
      wh = use_wr(u) && pending[a];
      if (rd_en[p] && (rh || wh) && !byp)
        hazard = 1'b1;
    end
  end

  // clears first, then sets: an issue claiming a register
  // beats a writeback draining it in the same cycle
  always_comb begin
    pend_nxt = pending;
    for (int w = 0; w < NUM_WB; w++)
      if (wb_en[w])
        pend_nxt[wb_addr[(NUM_WB-1-w)*REG_ADDR_W +: REG_ADDR_W]] = 1'b0;
    if (accept)
      for (int p = 0; p < NUM_RD; p++)
        if (rd_en[p] &&
            use_wr(reg_use_e'(rd_use[(NUM_RD-1-p)*USE_W +: USE_W])))
          pend_nxt[rd_addr[(NUM_RD-1-p)*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pend_nxt;
  end

endmodule

// File: rtl/fx_scoreboard_regfile.sv
// Register-read stage: regfile, operand mux, output hold register, debug.
// Ports: clock_i, reset_i, bus (slave). Multi-field buses: port 0 in MSBs.
// REGFILE_WB_BYPASS_EN forwards same-cycle writeback data to reads.
module fx_scoreboard_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 2**REG_ADDR_W,
  parameter int NUM_RD     = 3,
  parameter int NUM_WB     = 2,
  parameter int TAG_W      = 16
) (
  input logic                     clock_i,
  input logic                     reset_i,
  fx_scoreboard_regfile_if.slave  bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic                         hazard;
  logic                         issue_ready;
  logic                         accept;
  logic [NUM_RD*DATA_W-1:0]     operand_nxt;
  logic [NUM_RD-1:0]            dest_nxt;
  logic [REG_ADDR_W-1:0]        a;
  reg_use_e                     u;
  logic [DATA_W-1:0]            v;

  logic                         op_valid;
  logic [NUM_RD*DATA_W-1:0]     operand_q;
  logic [NUM_RD-1:0]            dest_valid_q;
  logic [NUM_RD*REG_ADDR_W-1:0] dest_addr_q;
  logic [TAG_W-1:0]             tag_q;
  logic [DATA_W-1:0]            dbg_q;

  fx_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_REGS   (NUM_REGS),
    .NUM_RD     (NUM_RD),
    .NUM_WB     (NUM_WB)
  ) u_sb (
    .clk     (clock_i),
    .rst     (reset_i),
    .accept  (accept),
    .rd_en   (bus.rd_en_i),
    .rd_addr (bus.rd_addr_i),
    .rd_use  (bus.rd_use_i),
    .rd_zero (bus.rd_zero_i),
    .wb_en   (bus.wb_en_i),
    .wb_addr (bus.wb_addr_i),
    .hazard  (hazard)
  );

  assign issue_ready = !reset_i && !hazard &&
                       (!op_valid || bus.op_ready_i);
  assign accept = bus.issue_valid_i && issue_ready;

  always_comb begin
    operand_nxt = '0;
    dest_nxt = '0;
    a = '0;
    u = REG_IMM;
    v = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      a = bus.rd_addr_i[(NUM_RD-1-p)*REG_ADDR_W +: REG_ADDR_W];
      u = reg_use_e'(bus.rd_use_i[(NUM_RD-1-p)*USE_W +: USE_W]);
      v = '0;
      if (bus.rd_en_i[p]) begin
        if (use_rd(u)) begin
          v = regs[a];
`ifdef REGFILE_WB_BYPASS_EN
          // ascending scan: highest matching port wins
          for (int w = 0; w < NUM_WB; w++)
            if (bus.wb_en_i[w] &&
                bus.wb_addr_i[(NUM_WB-1-w)*REG_ADDR_W +: REG_ADDR_W] == a)
              v = bus.wb_data_i[(NUM_WB-1-w)*DATA_W +: DATA_W];
`endif
          if (bus.rd_zero_i[p] && a == '0) v = '0;
        end else begin
          v = DATA_W'(a);
        end
      end
      operand_nxt[(NUM_RD-1-p)*DATA_W +: DATA_W] = v;
      dest_nxt[p] = bus.rd_en_i[p] && use_wr(u);
    end
  end

  // later port overrides earlier on an address collision
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int w = 0; w < NUM_WB; w++)
        if (bus.wb_en_i[w])
          regs[bus.wb_addr_i[(NUM_WB-1-w)*REG_ADDR_W +: REG_ADDR_W]]
            <= bus.wb_data_i[(NUM_WB-1-w)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      op_valid     <= 1'b0;
      operand_q    <= '0;
      dest_valid_q <= '0;
      dest_addr_q  <= '0;
      tag_q        <= '0;
    end else if (accept) begin
      op_valid     <= 1'b1;
      operand_q    <= operand_nxt;
      dest_valid_q <= dest_nxt;
      dest_addr_q  <= bus.rd_addr_i;
      tag_q        <= bus.tag_i;
    end else if (bus.op_ready_i) begin
      op_valid     <= 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) dbg_q <= '0;
    else         dbg_q <= regs[bus.dbg_addr_i];
  end

  assign bus.issue_ready_o = issue_ready;
  assign bus.op_valid_o    = op_valid;
  assign bus.operand_o     = operand_q;
  assign bus.dest_valid_o  = dest_valid_q;
  assign bus.dest_addr_o   = dest_addr_q;
  assign bus.tag_o         = tag_q;
  assign bus.dbg_data_o    = dbg_q;

endmodule

// File: tb/tb_fx_scoreboard_regfile.sv
// Self-checking bench for fx_scoreboard_regfile.
// Directed test-plan steps plus random traffic against a reference model.
module tb_fx_scoreboard_regfile;
  import regfile_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int NW = 2;
  localparam int TW = 16;
  localparam int NREG = 2**AW;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [NR*DW-1:0] op;
    logic [NR-1:0]    dv;
    logic [NR*AW-1:0] da;
    logic [TW-1:0]    tag;
  } bundle_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fx_scoreboard_regfile_if #(
    .DATA_W(DW), .REG_ADDR_W(AW), .NUM_RD(NR),
    .NUM_WB(NW), .TAG_W(TW)
  ) bus ();

  fx_scoreboard_regfile #(
    .DATA_W(DW), .REG_ADDR_W(AW), .NUM_REGS(NREG),
    .NUM_RD(NR), .NUM_WB(NW), .TAG_W(TW)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  logic          en   [NR];
  logic [1:0]    use_ [NR];
  logic [AW-1:0] addr [NR];
  logic          zr   [NR];
  logic          wbe  [NW];
  logic [AW-1:0] wba  [NW];
  logic [DW-1:0] wbd  [NW];

  always_comb begin
    for (int p = 0; p < NR; p++) begin
      bus.rd_en_i[p] = en[p];
      bus.rd_zero_i[p] = zr[p];
      bus.rd_addr_i[(NR-1-p)*AW +: AW] = addr[p];
      bus.rd_use_i[(NR-1-p)*2 +: 2] = use_[p];
    end
    for (int w = 0; w < NW; w++) begin
      bus.wb_en_i[w] = wbe[w];
      bus.wb_addr_i[(NW-1-w)*AW +: AW] = wba[w];
      bus.wb_data_i[(NW-1-w)*DW +: DW] = wbd[w];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0]   mregs [NREG];
  logic [NREG-1:0] mpend = '0;
  logic            mov = 1'b0;
  logic [DW-1:0]   mdbg = '0;
  bundle_t         q [$];

  initial for (int i = 0; i < NREG; i++) mregs[i] = '0;

  function automatic logic wb_hit(input logic [AW-1:0] a);
    logic h = 1'b0;
    for (int w = 0; w < NW; w++)
      if (wbe[w] && wba[w] == a) h = 1'b1;
    return h;
  endfunction

  function automatic logic m_hazard();
    logic h = 1'b0;
    for (int p = 0; p < NR; p++) begin
      logic pd, rd, wr;
      pd = mpend[addr[p]];
      rd = use_[p][0] && pd && !(zr[p] && addr[p] == '0);
      wr = use_[p][1] && pd;
      if (en[p] && (rd || wr) && !(BYP && wb_hit(addr[p])))
        h = 1'b1;
    end
    return h;
  endfunction

  function automatic logic m_ready();
    return !rst && !m_hazard() && (!mov || bus.op_ready_i);
  endfunction

  function automatic logic [DW-1:0] exp_operand(input int p);
    logic [DW-1:0] v;
    if (!en[p]) return '0;
    if (!use_[p][0]) return DW'(addr[p]);
    if (zr[p] && addr[p] == '0) return '0;
    v = mregs[addr[p]];
    if (BYP)
      for (int w = 0; w < NW; w++)
        if (wbe[w] && wba[w] == addr[p]) v = wbd[w];
    return v;
  endfunction

  always @(posedge clk) begin
    bundle_t b;
    logic acc;
    logic [NREG-1:0] np;
    acc = bus.issue_valid_i && m_ready();
    if (rst) begin
      q.delete();
      mov <= 1'b0;
      mdbg <= '0;
      mpend <= '0;
      for (int i = 0; i < NREG; i++) mregs[i] <= '0;
    end else begin
      mdbg <= mregs[bus.dbg_addr_i];
      if (mov && bus.op_ready_i && q.size() > 0)
        void'(q.pop_front());
      if (acc) begin
        for (int p = 0; p < NR; p++) begin
          b.op[(NR-1-p)*DW +: DW] = exp_operand(p);
          b.dv[p] = en[p] && use_[p][1];
          b.da[(NR-1-p)*AW +: AW] = addr[p];
        end
        b.tag = bus.tag_i;
        q.push_back(b);
      end
      mov <= acc ? 1'b1 : (bus.op_ready_i ? 1'b0 : mov);
      np = mpend;
      for (int w = 0; w < NW; w++) if (wbe[w]) np[wba[w]] = 1'b0;
      if (acc)
        for (int p = 0; p < NR; p++)
          if (en[p] && use_[p][1]) np[addr[p]] = 1'b1;
      mpend <= np;
      for (int w = 0; w < NW; w++)
        if (wbe[w]) mregs[wba[w]] <= wbd[w];
    end
  end

  always @(negedge clk) begin
    check("issue_ready", 64'(bus.issue_ready_o), 64'(m_ready()));
    check("op_valid", 64'(bus.op_valid_o), 64'(mov));
    check("dbg_data", bus.dbg_data_o, mdbg);
    if (mov && q.size() > 0) begin
      for (int p = 0; p < NR; p++) begin
        check("operand", bus.operand_o[(NR-1-p)*DW +: DW],
              q[0].op[(NR-1-p)*DW +: DW]);
        check("dest_addr", 64'(bus.dest_addr_o[(NR-1-p)*AW +: AW]),
              64'(q[0].da[(NR-1-p)*AW +: AW]));
      end
      check("dest_valid", 64'(bus.dest_valid_o), 64'(q[0].dv));
      check("tag", 64'(bus.tag_o), 64'(q[0].tag));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_ports();
    for (int p = 0; p < NR; p++) begin
      en[p] = 1'b0; use_[p] = 2'd0; addr[p] = '0; zr[p] = 1'b0;
    end
  endtask

  task automatic clear_wb();
    for (int w = 0; w < NW; w++) begin
      wbe[w] = 1'b0; wba[w] = '0; wbd[w] = '0;
    end
  endtask

  task automatic set_port(input int p, input reg_use_e u,
                          input logic [AW-1:0] a, input logic z);
    en[p] = 1'b1; use_[p] = u; addr[p] = a; zr[p] = z;
  endtask

  task automatic set_wb(input int w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    wbe[w] = 1'b1; wba[w] = a; wbd[w] = d;
  endtask

  task automatic issue_wait(input logic [TW-1:0] t);
    logic got = 1'b0;
    bus.tag_i = t;
    bus.issue_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.issue_ready_o) begin got = 1'b1; break; end
    end
    check("accept", 64'(got), 64'd1);
    tick();
    bus.issue_valid_i = 1'b0;
    clear_ports();
    clear_wb();
  endtask

  // instruction already on the inputs, writeback freshly driven
  task automatic release_wait(input string name);
    logic acc = 1'b0;
    for (int i = 0; i < 5 && !acc; i++) begin
      @(negedge clk);
      acc = bus.issue_ready_o;
      tick();
      clear_wb();
    end
    check(name, 64'(acc), 64'd1);
    bus.issue_valid_i = 1'b0;
    clear_ports();
  endtask

  task automatic wait_tag(input logic [TW-1:0] t,
                          input logic [DW-1:0] exp, input string name);
    logic found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.op_valid_o && bus.tag_o == t) begin found = 1'b1; break; end
    end
    check({name, "_seen"}, 64'(found), 64'd1);
    check(name, bus.operand_o[NR*DW-1 -: DW], exp);
    tick();
  endtask

  // ---------------- sequence ----------------
  initial begin
    bus.issue_valid_i = 1'b0;
    bus.tag_i = '0;
    bus.op_ready_i = 1'b1;
    bus.dbg_addr_i = '0;
    clear_ports();
    clear_wb();

    repeat (3) @(posedge clk);
    #1;
    check("rst_op_valid", 64'(bus.op_valid_o), 64'd0);
    check("rst_operand0", bus.operand_o[NR*DW-1 -: DW], 64'd0);
    check("rst_operand2", bus.operand_o[DW-1:0], 64'd0);
    check("rst_dest", 64'({bus.dest_valid_o, bus.dest_addr_o}), 64'd0);
    check("rst_tag", 64'(bus.tag_o), 64'd0);
    check("rst_dbg", bus.dbg_data_o, 64'd0);
    check("rst_ready", 64'(bus.issue_ready_o), 64'd0);
    rst = 1'b0;

    // write then read r5
    set_wb(0, 5, 64'h1234);
    tick();
    clear_wb();
    set_port(0, REG_READ, 5, 1'b0);
    issue_wait(16'd1);
    check("latency", 64'(bus.op_valid_o), 64'd1);
    wait_tag(16'd1, 64'h1234, "r5_read");

    // RAW on r7 resolved by writeback
    set_port(0, REG_WRITE, 7, 1'b0);
    issue_wait(16'd2);
    set_port(0, REG_READ, 7, 1'b0);
    bus.tag_i = 16'd3;
    bus.issue_valid_i = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("raw_stall", 64'(bus.issue_ready_o), 64'd0);
    tick();
    set_wb(0, 7, 64'hAA);
    @(negedge clk);
    check("raw_bypass", 64'(bus.issue_ready_o), 64'(BYP));
    tick();
    clear_wb();
    if (!bus.op_valid_o || bus.tag_o != 16'd3) begin
      set_port(0, REG_READ, 7, 1'b0);
      release_wait("raw_accept");
    end
    bus.issue_valid_i = 1'b0;
    clear_ports();
    wait_tag(16'd3, 64'hAA, "raw_data");

    // hard-wired zero vs real r0
    set_wb(0, 0, 64'hFF);
    tick();
    clear_wb();
    set_port(0, REG_READ, 0, 1'b1);
    issue_wait(16'd4);
    wait_tag(16'd4, 64'h0, "r0_zero");
    set_port(0, REG_READ, 0, 1'b0);
    issue_wait(16'd5);
    wait_tag(16'd5, 64'hFF, "r0_real");

    // hold under back-pressure
    bus.op_ready_i = 1'b0;
    set_port(0, REG_READ, 5, 1'b0);
    issue_wait(16'd6);
    set_port(0, REG_IMM, 17, 1'b0);
    set_port(1, REG_READ, 3, 1'b0);
    bus.tag_i = 16'd7;
    bus.issue_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_ready", 64'(bus.issue_ready_o), 64'd0);
      check("hold_tag", 64'(bus.tag_o), 64'd6);
      check("hold_op", bus.operand_o[NR*DW-1 -: DW], 64'h1234);
      tick();
    end
    bus.op_ready_i = 1'b1;
    @(negedge clk);
    check("release_ready", 64'(bus.issue_ready_o), 64'd1);
    tick();
    bus.issue_valid_i = 1'b0;
    clear_ports();
    wait_tag(16'd7, 64'd17, "imm_field");

    // two writebacks to r3: port 1 wins
    set_wb(0, 3, 64'h1);
    set_wb(1, 3, 64'h2);
    tick();
    clear_wb();
    bus.dbg_addr_i = 5'd3;
    tick();
    tick();
    check("wb_priority", bus.dbg_data_o, 64'h2);
    set_port(0, REG_READ, 3, 1'b0);
    issue_wait(16'd8);
    wait_tag(16'd8, 64'h2, "r3_read");

    // set beats clear on r9
    set_wb(0, 9, 64'h99);
    set_port(0, REG_WRITE, 9, 1'b0);
    issue_wait(16'd9);
    set_port(0, REG_READ, 9, 1'b0);
    bus.tag_i = 16'd10;
    bus.issue_valid_i = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("set_wins", 64'(bus.issue_ready_o), 64'd0);
    tick();
    set_wb(1, 9, 64'h55);
    release_wait("r9_accept");
    wait_tag(16'd10, 64'h55, "r9_data");

    // reset drops the held bundle and the scoreboard
    bus.op_ready_i = 1'b0;
    set_port(0, REG_WRITE, 12, 1'b0);
    issue_wait(16'd11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_drop", 64'(bus.op_valid_o), 64'd0);
    bus.op_ready_i = 1'b1;
    set_port(0, REG_READ, 12, 1'b0);
    issue_wait(16'd12);
    wait_tag(16'd12, 64'h0, "r12_after_rst");

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NR; p++) begin
        en[p] = 1'($urandom_range(0, 1));
        use_[p] = 2'($urandom_range(0, 3));
        addr[p] = AW'($urandom_range(0, 7));
        zr[p] = 1'($urandom_range(0, 1));
      end
      for (int w = 0; w < NW; w++) begin
        wbe[w] = 1'($urandom_range(0, 1));
        wba[w] = AW'($urandom_range(0, 7));
        wbd[w] = {32'($urandom), 32'($urandom)};
      end
      bus.issue_valid_i = 1'($urandom_range(0, 1));
      bus.op_ready_i = ($urandom_range(0, 3) != 0);
      bus.tag_i = TW'($urandom);
      bus.dbg_addr_i = AW'($urandom_range(0, 7));
      tick();
    end

    bus.issue_valid_i = 1'b0;
    bus.op_ready_i = 1'b1;
    clear_ports();
    clear_wb();
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
